// File: rtl/instr_enc_pkg.sv
// Shared definitions for the instruction encoder: format codes, fixed opcodes,
// immediate range limits and the FSM state type.
package instr_enc_pkg;

  typedef enum logic [2:0] {
    FMT_I    = 3'd0,
    FMT_S    = 3'd1,
    FMT_B    = 3'd2,
    FMT_U    = 3'd3,
    FMT_J    = 3'd4,
    FMT_LI   = 3'd5,
    FMT_ILL6 = 3'd6,
    FMT_ILL7 = 3'd7
  } fmt_e;

  typedef enum logic {
    ST_IDLE,
    ST_SECOND
  } state_e;

  localparam logic [6:0]  OPCODE_OP_IMM = 7'b0010011;
  localparam logic [6:0]  OPCODE_LUI    = 7'b0110111;
  localparam logic [31:0] NOP_INSTR     = 32'h0000_0013;

  localparam int signed IMM12_MIN = -2048;
  localparam int signed IMM12_MAX = 2047;
  localparam int signed IMM_B_MIN = -4096;
  localparam int signed IMM_B_MAX = 4094;
  localparam int signed IMM_J_MIN = -(1 << 20);
  localparam int signed IMM_J_MAX = (1 << 20) - 2;

  function automatic logic in_range(input logic [31:0] v, input int signed lo,
                                    input int signed hi);
    return ($signed(v) >= lo) && ($signed(v) <= hi);
  endfunction

endpackage

// File: rtl/imm_packer.sv
// Combinational field packer for the single-instruction formats; flags range
// and illegal-format errors. LI is split by the parent, so its output is unused.
module imm_packer
  import instr_enc_pkg::*;
#(
  parameter int RANGE_CHECK = 1
) (
  input  logic [2:0]  fmt,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [31:0] imm,
  output logic [31:0] instr,
  output logic        err
);

  fmt_e fmt_sel;
  logic range_err;
  logic illegal;

  assign fmt_sel = fmt_e'(fmt);

  // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and infers a latch.
  always_comb begin
    instr     = NOP_INSTR;
    range_err = 1'b0;
    illegal   = 1'b0;
    case (fmt_sel)
      FMT_I: begin
        instr     = {imm[11:0], rs1, funct3, rd, opcode};
        range_err = !in_range(imm, IMM12_MIN, IMM12_MAX);
      end
      FMT_S: begin
        instr     = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
        range_err = !in_range(imm, IMM12_MIN, IMM12_MAX);
      end
      FMT_B: begin
        instr     = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
        range_err = !in_range(imm, IMM_B_MIN, IMM_B_MAX) || imm[0];
      end
      FMT_U: begin
        instr     = {imm[31:12], rd, opcode};
        range_err = (imm[11:0] != 12'd0);
      end
      FMT_J: begin
        instr     = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
        range_err = !in_range(imm, IMM_J_MIN, IMM_J_MAX) || imm[0];
      end
      FMT_LI: instr = NOP_INSTR;
      default: illegal = 1'b1;
    endcase
    err = illegal || ((RANGE_CHECK != 0) && range_err);
  end

endmodule

// File: rtl/instruction_encoder.sv
// Handshaked instruction encoder: registers one encoded instruction per request,
// expanding the LI pseudo-op into LUI+ADDI when the value needs both.
module instruction_encoder
  import instr_enc_pkg::*;
#(
  parameter int RANGE_CHECK = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  fmt,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [31:0] imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic        out_err,
  output logic        out_last
);

  state_e      state_q, state_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] out_instr_q, out_instr_d;
  logic        out_err_q, out_err_d;
  logic        out_last_q, out_last_d;
  logic [31:0] pend_instr_q, pend_instr_d;

  logic [31:0] pack_instr;
  logic        pack_err;
  logic        accept;
  logic        out_fire;
  logic [19:0] li_hi;
  logic        li_small;
  logic [31:0] li_lui;
  logic [31:0] li_addi_x0;
  logic [31:0] li_addi_rd;

  imm_packer #(.RANGE_CHECK(RANGE_CHECK)) u_packer (
    .fmt    (fmt),
    .opcode (opcode),
    .funct3 (funct3),
    .rd     (rd),
    .rs1    (rs1),
    .rs2    (rs2),
    .imm    (imm),
    .instr  (pack_instr),
    .err    (pack_err)
  );

  assign in_ready = (state_q == ST_IDLE) && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign out_fire = out_valid_q && out_ready;

  // The ADDI sign-extends its low 12 bits, so a set imm[11] borrows one from hi.
  assign li_hi      = imm[31:12] + {19'd0, imm[11]};
  assign li_small   = in_range(imm, IMM12_MIN, IMM12_MAX);
  assign li_lui     = {li_hi, rd, OPCODE_LUI};
  assign li_addi_x0 = {imm[11:0], 5'd0, 3'b000, rd, OPCODE_OP_IMM};
  assign li_addi_rd = {imm[11:0], rd, 3'b000, rd, OPCODE_OP_IMM};

  always_comb begin
    state_d      = state_q;
    out_valid_d  = out_valid_q;
    out_instr_d  = out_instr_q;
    out_err_d    = out_err_q;
    out_last_d   = out_last_q;
    pend_instr_d = pend_instr_q;
    if (out_fire) out_valid_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          out_valid_d = 1'b1;
          out_err_d   = 1'b0;
          out_last_d  = 1'b1;
          if (fmt_e'(fmt) == FMT_LI) begin
            if (li_small) begin
              out_instr_d = li_addi_x0;
            end else if (imm[11:0] == 12'd0) begin
              out_instr_d = li_lui;
            end else begin
              out_instr_d  = li_lui;
              out_last_d   = 1'b0;
              pend_instr_d = li_addi_rd;
              state_d      = ST_SECOND;
            end
          end else begin
            out_instr_d = pack_instr;
            out_err_d   = pack_err;
          end
        end
      end
      ST_SECOND: begin
        // The LUI beat is still on the output; swap in ADDI as it leaves.
        if (out_fire) begin
          out_valid_d = 1'b1;
          out_instr_d = pend_instr_q;
          out_err_d   = 1'b0;
          out_last_d  = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      out_valid_q  <= 1'b0;
      out_instr_q  <= 32'd0;
      out_err_q    <= 1'b0;
      out_last_q   <= 1'b0;
      pend_instr_q <= 32'd0;
    end else begin
      state_q      <= state_d;
      out_valid_q  <= out_valid_d;
      out_instr_q  <= out_instr_d;
      out_err_q    <= out_err_d;
      out_last_q   <= out_last_d;
      pend_instr_q <= pend_instr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_instr = out_instr_q;
  assign out_err   = out_err_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_instruction_encoder.sv
// Directed bench for instruction_encoder: a table of single-beat encodings plus
// hand sequences for LI splitting, back-pressure, throughput and mid-LI reset.
module tb_instruction_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  fmt;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [4:0]  rd, rs1, rs2;
  logic [31:0] imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        out_err;
  logic        out_last;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [2:0]  fmt;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic [31:0] exp_instr;
    logic        exp_err;
  } vec_t;

  localparam int NV = 19;
  vec_t vecs[NV];

  instruction_encoder dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .fmt       (fmt),
    .opcode    (opcode),
    .funct3    (funct3),
    .rd        (rd),
    .rs1       (rs1),
    .rs2       (rs2),
    .imm       (imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_err   (out_err),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    fmt    = v.fmt;
    opcode = v.opcode;
    funct3 = v.funct3;
    rd     = v.rd;
    rs1    = v.rs1;
    rs2    = v.rs2;
    imm    = v.imm;
  endtask

  // Presents one request for one cycle; outputs are sampled 1 time unit after the edge.
  task automatic issue(input vec_t v, input string tag);
    @(negedge clk);
    drive(v);
    in_valid = 1'b1;
    check({tag, " in_ready"}, {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic check_out(input string tag, input logic [31:0] instr, input logic err,
                           input logic last);
    check({tag, " out_valid"}, {31'd0, out_valid}, 32'd1);
    check({tag, " out_instr"}, out_instr, instr);
    check({tag, " out_err"}, {31'd0, out_err}, {31'd0, err});
    check({tag, " out_last"}, {31'd0, out_last}, {31'd0, last});
  endtask

  vec_t li_big, li_800, i_vec;

  initial begin
    //              fmt   opcode  f3    rd     rs1    rs2    imm            instr          err
    vecs[0]  = '{3'd0, 7'h13, 3'd0, 5'd1,  5'd0,  5'd0,  32'hFFFF_FFFF, 32'hFFF0_0093, 1'b0};
    vecs[1]  = '{3'd2, 7'h63, 3'd0, 5'd0,  5'd1,  5'd2,  32'hFFFF_FFFC, 32'hFE20_8EE3, 1'b0};
    vecs[2]  = '{3'd2, 7'h63, 3'd0, 5'd0,  5'd1,  5'd2,  32'h0000_0003, 32'h0020_8163, 1'b1};
    vecs[3]  = '{3'd6, 7'h33, 3'd1, 5'd3,  5'd4,  5'd5,  32'h0000_0010, 32'h0000_0013, 1'b1};
    vecs[4]  = '{3'd7, 7'h33, 3'd1, 5'd3,  5'd4,  5'd5,  32'h0000_0010, 32'h0000_0013, 1'b1};
    vecs[5]  = '{3'd3, 7'h37, 3'd0, 5'd1,  5'd0,  5'd0,  32'h0000_1001, 32'h0000_10B7, 1'b1};
    vecs[6]  = '{3'd3, 7'h37, 3'd0, 5'd3,  5'd0,  5'd0,  32'h1234_5000, 32'h1234_51B7, 1'b0};
    vecs[7]  = '{3'd1, 7'h23, 3'd2, 5'd0,  5'd2,  5'd3,  32'h0000_07FF, 32'h7E31_2FA3, 1'b0};
    vecs[8]  = '{3'd0, 7'h13, 3'd0, 5'd1,  5'd0,  5'd0,  32'h0000_0800, 32'h8000_0093, 1'b1};
    vecs[9]  = '{3'd0, 7'h13, 3'd0, 5'd1,  5'd0,  5'd0,  32'hFFFF_F800, 32'h8000_0093, 1'b0};
    vecs[10] = '{3'd2, 7'h63, 3'd0, 5'd0,  5'd1,  5'd2,  32'h0000_0FFE, 32'h7E20_8FE3, 1'b0};
    vecs[11] = '{3'd2, 7'h63, 3'd0, 5'd0,  5'd1,  5'd2,  32'h0000_1000, 32'h8020_8063, 1'b1};
    vecs[12] = '{3'd4, 7'h6F, 3'd0, 5'd1,  5'd0,  5'd0,  32'h0000_0800, 32'h0010_00EF, 1'b0};
    vecs[13] = '{3'd4, 7'h6F, 3'd0, 5'd1,  5'd0,  5'd0,  32'h0000_0001, 32'h0000_00EF, 1'b1};
    vecs[14] = '{3'd4, 7'h6F, 3'd0, 5'd1,  5'd0,  5'd0,  32'h0010_0000, 32'h8000_00EF, 1'b1};
    vecs[15] = '{3'd4, 7'h6F, 3'd0, 5'd1,  5'd0,  5'd0,  32'hFFF0_0000, 32'h8000_00EF, 1'b0};
    vecs[16] = '{3'd5, 7'h00, 3'd0, 5'd1,  5'd0,  5'd0,  32'hFFFF_FFFF, 32'hFFF0_0093, 1'b0};
    vecs[17] = '{3'd5, 7'h7F, 3'd7, 5'd2,  5'd31, 5'd31, 32'h7FFF_F000, 32'h7FFF_F137, 1'b0};
    vecs[18] = '{3'd5, 7'h7F, 3'd7, 5'd4,  5'd31, 5'd31, 32'h0000_07FF, 32'h7FF0_0213, 1'b0};

    li_big = '{3'd5, 7'h00, 3'd0, 5'd5, 5'd0, 5'd0, 32'h1234_5678, 32'h0, 1'b0};
    li_800 = '{3'd5, 7'h00, 3'd0, 5'd1, 5'd0, 5'd0, 32'h0000_0800, 32'h0, 1'b0};
    i_vec  = vecs[0];

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drive(vecs[0]);
    #1;
    check("reset out_valid", {31'd0, out_valid}, 32'd0);
    check("reset out_instr", out_instr, 32'd0);
    check("reset out_err", {31'd0, out_err}, 32'd0);
    check("reset out_last", {31'd0, out_last}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      issue(vecs[i], $sformatf("vec%0d", i));
      check_out($sformatf("vec%0d", i), vecs[i].exp_instr, vecs[i].exp_err, 1'b1);
    end
    @(posedge clk);
    #1;
    check("drain out_valid", {31'd0, out_valid}, 32'd0);

    // Two-beat LI with the sink always ready.
    issue(li_big, "li_big");
    check_out("li_big beat1", 32'h1234_52B7, 1'b0, 1'b0);
    check("li_big in_ready beat1", {31'd0, in_ready}, 32'd0);
    @(posedge clk);
    #1;
    check_out("li_big beat2", 32'h6782_8293, 1'b0, 1'b1);
    issue(li_800, "li_800");
    check_out("li_800 beat1", 32'h0000_10B7, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check_out("li_800 beat2", 32'h8000_8093, 1'b0, 1'b1);
    @(posedge clk);
    #1;

    // Back-pressure on the LUI beat.
    out_ready = 1'b0;
    issue(li_big, "stall");
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      check_out($sformatf("stall hold%0d", c), 32'h1234_52B7, 1'b0, 1'b0);
      check($sformatf("stall in_ready%0d", c), {31'd0, in_ready}, 32'd0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check_out("stall addi", 32'h6782_8293, 1'b0, 1'b1);
    @(posedge clk);
    #1;

    // Back-to-back single-beat requests, one per cycle.
    @(negedge clk);
    in_valid = 1'b1;
    for (int i = 7; i < 10; i++) begin
      drive(vecs[i]);
      @(posedge clk);
      #1;
      check_out($sformatf("b2b%0d", i), vecs[i].exp_instr, vecs[i].exp_err, 1'b1);
    end
    in_valid = 1'b0;
    @(posedge clk);
    #1;

    // Reset while the ADDI beat is pending.
    out_ready = 1'b0;
    issue(li_big, "rst_mid");
    check_out("rst_mid beat1", 32'h1234_52B7, 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check("rst_mid out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_mid out_instr", out_instr, 32'd0);
    check("rst_mid out_last", {31'd0, out_last}, 32'd0);
    @(negedge clk);
    rst       = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst in_ready", {31'd0, in_ready}, 32'd1);
    check("post_rst no addi", {31'd0, out_valid}, 32'd0);
    issue(i_vec, "post_rst");
    check_out("post_rst", 32'hFFF0_0093, 1'b0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
